// File: rtl/spi_master_if.sv
// SPI master host/pin bundle.
//   master modport : the spi_master side (drives pins and host results).
//   slave modport  : the host/board side (supplies requests and miso).
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  busy;
    logic                  sck;
    logic                  cs;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  data_in, data_in_valid, miso,
        output data_out, data_out_valid, busy, sck, cs, mosi
    );

    modport slave (
        output data_in, data_in_valid, miso,
        input  data_out, data_out_valid, busy, sck, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, one word per cs frame.
// Frame: SETUP (CLK_DIV) -> SHIFT (2*DATA_WIDTH half-periods) -> HOLD (CLK_DIV)
//        -> GAP (CLK_DIV). busy covers exactly (2*DATA_WIDTH+3)*CLK_DIV cycles.
// Optional macro SPI_MASTER_BURST_EN: a request seen in HOLD's last cycle
// starts the next word without deasserting cs (GAP skipped).
// CLK_DIV must be >= 4 and DATA_WIDTH >= 2.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    spi_master_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(2 * DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] FALL_LAST = BIT_W'(2 * DATA_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;      // clk count within the current half-period / phase
    logic [BIT_W-1:0]      r_half;     // sck half-period index; even = sck high
    logic [DATA_WIDTH-1:0] r_tx;       // MSB is the bit currently on mosi
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_dov;
    logic                  r_busy;
    logic                  r_sck;
    logic                  r_cs;
    logic                  r_miso_s1;
    logic                  r_miso_s2;
    logic                  w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    // Two-flop synchronizer for the asynchronous miso pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= bus.miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Frame sequencer: all pin and host outputs come straight from these registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_dov      <= 1'b0;
            r_busy     <= 1'b0;
            r_sck      <= 1'b0;
            r_cs       <= 1'b1;
        end else begin
            r_dov <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div  <= '0;
                    r_half <= '0;
                    if (bus.data_in_valid) begin
                        r_tx    <= bus.data_in;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        // First rising edge: slave has seen the MSB for a full half-period.
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[DATA_WIDTH-2:0], r_miso_s2};
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_half == HALF_LAST) begin
                            // Final low half done; sck is already 0.
                            r_half  <= '0;
                            r_state <= S_HOLD;
                        end else if (!r_half[0]) begin
                            // Falling edge; the last one leaves the final bit on mosi.
                            r_half <= r_half + 1'b1;
                            r_sck  <= 1'b0;
                            if (r_half != FALL_LAST)
                                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            r_half <= r_half + 1'b1;
                            r_sck  <= 1'b1;
                            r_rx   <= {r_rx[DATA_WIDTH-2:0], r_miso_s2};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Result is published during HOLD's last cycle.
                    if (r_div == DIV_PRE) begin
                        r_data_out <= r_rx;
                        r_dov      <= 1'b1;
                    end
                    if (w_div_end) begin
                        r_div <= '0;
`ifdef SPI_MASTER_BURST_EN
                        if (bus.data_in_valid) begin
                            r_tx    <= bus.data_in;
                            r_state <= S_SETUP;
                        end else begin
                            r_cs    <= 1'b1;
                            r_state <= S_GAP;
                        end
`else
                        r_cs    <= 1'b1;
                        r_state <= S_GAP;
`endif
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sck            = r_sck;
    assign bus.cs             = r_cs;
    assign bus.mosi           = r_tx[DATA_WIDTH-1];
    assign bus.busy           = r_busy;
    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_dov;

endmodule
